// File: rtl/ahb_prior_scheduler_if.sv
// rtl/ahb_prior_scheduler_if.sv - request/grant/config/priority bundle for the priority scheduler
interface ahb_prior_scheduler_if #(
  parameter int SLAVE_X_MASTER_NUM = 4,
  parameter int SLAVE_X_PRIOR_BIT  = 2
);
  localparam int IDX_W = (SLAVE_X_MASTER_NUM > 1) ? $clog2(SLAVE_X_MASTER_NUM) : 1;

  logic [SLAVE_X_MASTER_NUM-1:0]                        hreq;
  logic [SLAVE_X_MASTER_NUM-1:0]                        hgrant;
  logic                                                 cfg_we;
  logic [IDX_W-1:0]                                     cfg_idx;
  logic [SLAVE_X_PRIOR_BIT-1:0]                         cfg_prior;
  logic [SLAVE_X_MASTER_NUM-1:0][SLAVE_X_PRIOR_BIT-1:0] hprior;
  logic [SLAVE_X_MASTER_NUM-1:0]                        starve;

  // Drives requests, grants and config; observes priorities
  modport master (
    output hreq, hgrant, cfg_we, cfg_idx, cfg_prior,
    input  hprior, starve
  );

  // The scheduler side
  modport slave (
    input  hreq, hgrant, cfg_we, cfg_idx, cfg_prior,
    output hprior, starve
  );
endinterface

// File: rtl/ahb_prior_scheduler.sv
// rtl/ahb_prior_scheduler.sv - per-master starvation aging with priority boost
module ahb_prior_scheduler #(
  parameter int SLAVE_X_MASTER_NUM  = 4,
  parameter int SLAVE_X_PRIOR_LEVEL = 4,
  parameter int SLAVE_X_PRIOR_BIT   = $clog2(SLAVE_X_PRIOR_LEVEL),
  parameter int AGE_LIMIT           = 8
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  ahb_prior_scheduler_if.slave bus
);
  localparam int M  = SLAVE_X_MASTER_NUM;
  localparam int PB = SLAVE_X_PRIOR_BIT;
  localparam int AW = $clog2(AGE_LIMIT + 1);

  localparam logic [AW-1:0] AGE_MAX  = AW'(AGE_LIMIT);
  localparam logic [AW-1:0] AGE_EDGE = AW'(AGE_LIMIT - 1);
  localparam logic [PB-1:0] PRIO_MAX = PB'(SLAVE_X_PRIOR_LEVEL - 1);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_BOOST  = 1'b1;

  logic [PB-1:0]         r_base   [M];
  logic [AW-1:0]         r_age    [M];
  logic [0:0]            r_state  [M];
  logic [M-1:0][PB-1:0]  r_hprior;
  logic [M-1:0]          r_starve;

  logic [M-1:0]          w_inc;
  logic [PB-1:0]         w_base_nxt  [M];
  logic [AW-1:0]         w_age_nxt   [M];
  logic [0:0]            w_state_nxt [M];
  logic [M-1:0][PB-1:0]  w_hprior_nxt;

  // Next-state for every master: a grant or a dropped request always ends starvation
  always_comb begin
    w_inc        = '0;
    w_hprior_nxt = '0;
    for (int i = 0; i < M; i++) begin
      w_inc[i] = bus.hreq[i] & ~bus.hgrant[i];

      w_base_nxt[i] = (bus.cfg_we && (int'(bus.cfg_idx) == i)) ? bus.cfg_prior : r_base[i];

      if (!w_inc[i]) begin
        w_age_nxt[i] = '0;
      end else if (r_age[i] == AGE_MAX) begin
        w_age_nxt[i] = r_age[i];
      end else begin
        w_age_nxt[i] = r_age[i] + AW'(1);
      end

      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_NORMAL: if (w_inc[i] && (r_age[i] == AGE_EDGE)) w_state_nxt[i] = ST_BOOST;
        default:   if (!w_inc[i])                          w_state_nxt[i] = ST_NORMAL;
      endcase

      w_hprior_nxt[i] = (w_state_nxt[i] == ST_BOOST) ? PRIO_MAX : w_base_nxt[i];
    end
  end

  // Register all per-master state; reset overrides any config write in the same cycle
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      for (int i = 0; i < M; i++) begin
        r_base[i]  <= '0;
        r_age[i]   <= '0;
        r_state[i] <= ST_NORMAL;
      end
      r_hprior <= '0;
      r_starve <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        r_base[i]   <= w_base_nxt[i];
        r_age[i]    <= w_age_nxt[i];
        r_state[i]  <= w_state_nxt[i];
        r_starve[i] <= (w_state_nxt[i] == ST_BOOST);
      end
      r_hprior <= w_hprior_nxt;
    end
  end

  assign bus.hprior = r_hprior;
  assign bus.starve = r_starve;
endmodule

// File: tb/tb_ahb_prior_scheduler.sv
// tb/tb_ahb_prior_scheduler.sv - scoreboard bench for ahb_prior_scheduler
module tb_ahb_prior_scheduler;
  localparam int M     = 4;
  localparam int LEVEL = 4;
  localparam int PB    = 2;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [M*PB-1:0] hp;
    logic [M-1:0]    st;
  } exp_t;

  logic hclk = 1'b0;
  logic hreset_n;

  ahb_prior_scheduler_if #(.SLAVE_X_MASTER_NUM(M), .SLAVE_X_PRIOR_BIT(PB)) bus ();

  ahb_prior_scheduler #(
    .SLAVE_X_MASTER_NUM (M),
    .SLAVE_X_PRIOR_LEVEL(LEVEL),
    .SLAVE_X_PRIOR_BIT  (PB),
    .AGE_LIMIT          (LIMIT)
  ) dut (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: a master is boosted exactly while it has been starved for
  // at least LIMIT consecutive cycles; otherwise it shows its configured base.
  int m_streak [M];
  int m_base   [M];

  task automatic cyc(input logic rst_n, input logic [M-1:0] req, input logic [M-1:0] grant,
                     input logic we, input logic [1:0] idx, input logic [PB-1:0] pr,
                     input string tag);
    exp_t e;
    @(negedge hclk);
    hreset_n      = rst_n;
    bus.hreq      = req;
    bus.hgrant    = grant;
    bus.cfg_we    = we;
    bus.cfg_idx   = idx;
    bus.cfg_prior = pr;
    e = '0;
    for (int i = 0; i < M; i++) begin
      if (!rst_n) begin
        m_streak[i] = 0;
        m_base[i]   = 0;
      end else begin
        if (we && int'(idx) == i) m_base[i] = int'(pr);
        if (req[i] && !grant[i]) m_streak[i] = (m_streak[i] > 1000) ? m_streak[i] : m_streak[i] + 1;
        else                     m_streak[i] = 0;
      end
      e.st[i] = (m_streak[i] >= LIMIT);
      e.hp[i*PB +: PB] = e.st[i] ? PB'(LEVEL - 1) : PB'(m_base[i]);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(1'b1, '0, '0, 1'b0, 2'd0, '0, tag);
  endtask

  task automatic starve_cycles(input logic [M-1:0] req, input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(1'b1, req, '0, 1'b0, 2'd0, '0, tag);
  endtask

  // Monitor: compares the registered outputs shortly after each rising edge
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge hclk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if (bus.hprior !== e.hp) begin
          n_fail++;
          $display("FAIL %s hprior: got %h expected %h at %0t", t, bus.hprior, e.hp, $time);
        end
        n_checks++;
        if (bus.starve !== e.st) begin
          n_fail++;
          $display("FAIL %s starve: got %b expected %b at %0t", t, bus.starve, e.st, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] r_req;
    logic [M-1:0] r_gnt;
    for (int i = 0; i < M; i++) begin
      m_streak[i] = 0;
      m_base[i]   = 0;
    end
    hreset_n      = 1'b0;
    bus.hreq      = '0;
    bus.hgrant    = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_prior = '0;

    cyc(1'b0, '0, '0, 1'b0, 2'd0, '0, "reset");
    cyc(1'b0, '0, '0, 1'b1, 2'd1, 2'd3, "reset_cfg_ignored");
    idle(1, "after_reset");

    cyc(1'b1, '0, '0, 1'b1, 2'd2, 2'd1, "cfg_idx2");
    idle(1, "cfg_hold");

    starve_cycles(4'b0001, LIMIT, "age0_to_boost");
    starve_cycles(4'b0001, 2, "boost0_hold");
    cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, '0, "boost0_grant");
    starve_cycles(4'b0001, LIMIT, "age0_restart");
    idle(1, "release0");

    starve_cycles(4'b0010, LIMIT - 1, "age1_to_7");
    cyc(1'b1, 4'b0010, 4'b0010, 1'b0, 2'd0, '0, "grant_at_limit");
    starve_cycles(4'b0010, LIMIT, "age1_restart");
    idle(1, "release1");

    starve_cycles(4'b1000, LIMIT, "age3_to_boost");
    cyc(1'b1, 4'b1000, '0, 1'b1, 2'd3, 2'd2, "cfg_in_boost");
    starve_cycles(4'b1000, 2, "boost3_hold");
    cyc(1'b1, 4'b0000, '0, 1'b0, 2'd0, '0, "boost3_exit");
    idle(1, "after_exit3");

    starve_cycles(4'b0011, LIMIT, "boost01");
    cyc(1'b0, 4'b0011, '0, 1'b1, 2'd0, 2'd3, "reset_in_boost");
    starve_cycles(4'b0011, LIMIT, "restarve01");
    idle(1, "release01");

    for (int n = 0; n < 600; n++) begin
      r_req = 4'($urandom_range(0, 15));
      r_gnt = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      cyc(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, r_req, r_gnt,
          ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          "random");
    end

    for (int k = 0; k < 3; k++) @(negedge hclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_prior_scheduler.md
AHB_PRIOR_SCHEDULER -- requirements
Module: ahb_prior_scheduler

Interface
REQ-001 The block SHALL have parameter SLAVE_X_MASTER_NUM, default 4: number of masters competing for one slave.
REQ-002 The block SHALL have parameter SLAVE_X_PRIOR_LEVEL, default 4: number of priority levels.
REQ-003 The block SHALL have parameter SLAVE_X_PRIOR_BIT, default $clog2(SLAVE_X_PRIOR_LEVEL): priority field width.
REQ-004 The block SHALL have parameter AGE_LIMIT, default 8 (legal 1..255): consecutive starved cycles before boost.
REQ-005 The block SHALL have port hclk, input, 1: single clock, all state on rising edge.
REQ-006 The block SHALL have port hreset_n, input, 1: reset, synchronous and active-low.
REQ-007 The block SHALL have port hreq, input, SLAVE_X_MASTER_NUM: per-master request to this slave.
REQ-008 The block SHALL have port hgrant, input, SLAVE_X_MASTER_NUM: one-hot grant from the slave arbiter, already qualified by ~hwait.
REQ-009 The block SHALL have port cfg_we, input, 1: base-priority write strobe.
REQ-010 The block SHALL have port cfg_idx, input, $clog2(SLAVE_X_MASTER_NUM): master index for a write.
REQ-011 The block SHALL have port cfg_prior, input, SLAVE_X_PRIOR_BIT: base priority value for a write.
REQ-012 The block SHALL have port hprior, output, [SLAVE_X_MASTER_NUM][SLAVE_X_PRIOR_BIT]: registered per-master priority for the dynamic-priority arbiter; larger value means higher priority.
REQ-013 The block SHALL have port starve, output, SLAVE_X_MASTER_NUM: registered flag, 1 while master i is in BOOST.

Function
REQ-014 The block SHALL hold one base_prior register per master, written on the rising edge when cfg_we=1 and cfg_idx<SLAVE_X_MASTER_NUM; out-of-range cfg_idx SHALL be ignored.
REQ-015 The block SHALL hold one age counter per master, $clog2(AGE_LIMIT+1) bits, saturating at AGE_LIMIT.
REQ-016 Age[i] SHALL increment by 1 when hreq[i]=1 and hgrant[i]=0, and SHALL clear to 0 when hreq[i]=0 or hgrant[i]=1; clear SHALL win over increment.
REQ-017 Each master SHALL have a 2-state FSM, NORMAL and BOOST.
REQ-018 The FSM SHALL go NORMAL->BOOST on the edge where age[i] would reach AGE_LIMIT, i.e. age[i]=AGE_LIMIT-1 with the increment condition true.
REQ-019 The FSM SHALL go BOOST->NORMAL on the edge where hgrant[i]=1 or hreq[i]=0; otherwise it SHALL stay in BOOST.
REQ-020 hprior[i] SHALL be registered: the next value is SLAVE_X_PRIOR_LEVEL-1 if the next FSM state is BOOST, else the next base_prior[i]. Priority therefore changes on the same edge as the state change and the config write.
REQ-021 starve[i] SHALL equal (FSM state == BOOST), registered.
REQ-022 Several masters MAY be in BOOST at once; the block SHALL NOT tie-break among them, which is the arbiter's job.
REQ-023 A cfg write to a master in BOOST SHALL update base_prior and SHALL leave hprior at the maximum until BOOST exits; hprior SHALL then take the new base on the exit edge.
REQ-024 A simultaneous grant and AGE_LIMIT crossing for the same master SHALL give NORMAL with age=0 (grant wins).
REQ-025 hgrant while hreq=0 SHALL be treated as a grant: age clears and the FSM stays NORMAL.
REQ-026 The block SHALL be purely synchronous with no combinational path from inputs to outputs.

Reset
REQ-027 When hreset_n=0 at a rising edge, the block SHALL set all base_prior=0, age=0, FSM=NORMAL, hprior=0 and starve=0. This applies mid-operation, including a master in BOOST, and cfg_we SHALL be ignored that cycle.
REQ-028 The first edge with hreset_n=1 SHALL resume normal counting from age 0.

Verification
REQ-029 The bench SHALL cover: reset, then cfg_we with idx=2, prior=1 -> hprior[2]=1 the next cycle, all others 0, starve=0.
REQ-030 The bench SHALL cover: hreq[0]=1 with hgrant=0 for 8 cycles (AGE_LIMIT=8) -> starve[0]=1 and hprior[0]=3 after the 8th edge; neither is set after the 7th edge.
REQ-031 The bench SHALL cover: master 0 in BOOST, then hgrant=4'b0001 for one cycle -> the next cycle starve[0]=0, hprior[0]=base, and age restarts at 0.
REQ-032 The bench SHALL cover: hgrant[1] asserted on the same edge as age[1]=7 with hreq[1]=1 -> starve[1] stays 0 and age[1]=0.
REQ-033 The bench SHALL cover: master 3 in BOOST, write cfg_prior=2 to idx 3, then drop hreq[3] -> hprior[3] stays 3 until the exit edge, then reads 2.
REQ-034 The bench SHALL cover: hreset_n=0 for one cycle while masters 0 and 1 are in BOOST -> the next cycle all hprior=0 and starve=0, and re-starvation takes the full 8 cycles.
